// File: rtl/fcp6_txn_arbiter.sv
// fcp6_txn_arbiter: round-robin scheduler sharing one FCP6 master among NUM_REQ clients.
// Optional watchdog abort is enabled by defining FCP6_ARB_WDOG_EN.
module fcp6_txn_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_header,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic                 m_start,
  output logic [7:0]           m_header,
  output logic [7:0]           m_data,
  input  logic                 m_busy,
  output logic                 arb_busy
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, COMPLETE} state_t;
  state_t state, state_d;
  logic [IW-1:0] rr_ptr, rr_ptr_d, idx, idx_d, win;
  logic found, abort, waiting, m_start_d;
  logic [NUM_REQ-1:0] gnt_d, done_d, err_d;
  logic [7:0] hdr_d, dat_d;
  assign waiting = state == WAIT_BUSY || state == WAIT_DONE;
  assign arb_busy = state != IDLE;
  always_comb begin
    int j;
    found = 1'b0;
    win = '0;
    j = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr) + i;
      j = j >= NUM_REQ ? j - NUM_REQ : j;
      if (!found && req[j]) begin
        found = 1'b1;
        win = IW'(j);
      end
    end
  end
`ifdef FCP6_ARB_WDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt, wd_cnt_d;
  // Cleared during LAUNCH so the first WAIT_BUSY cycle starts counting from zero.
  always_comb begin
    wd_cnt_d = state == LAUNCH ? '0 : waiting ? wd_cnt + 1'b1 : wd_cnt;
    abort = waiting && wd_cnt_d == CW'(TIMEOUT);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) wd_cnt <= '0;
    else wd_cnt <= wd_cnt_d;
`else
  assign abort = TIMEOUT < 0;
`endif
  always_comb begin
    state_d = state;
    rr_ptr_d = rr_ptr;
    idx_d = idx;
    gnt_d = gnt;
    done_d = '0;
    err_d = '0;
    m_start_d = 1'b0;
    hdr_d = m_header;
    dat_d = m_data;
    case (state)
      IDLE: if (found && !m_busy) begin
        state_d = LAUNCH;
        idx_d = win;
        gnt_d = NUM_REQ'(1) << win;
        m_start_d = 1'b1;
        hdr_d = req_header[{win, 3'b000} +: 8];
        dat_d = req_data[{win, 3'b000} +: 8];
      end
      LAUNCH: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        state_d = abort ? COMPLETE : m_busy ? WAIT_DONE : WAIT_BUSY;
        err_d = abort ? gnt : '0;
      end
      WAIT_DONE: begin
        state_d = abort || !m_busy ? COMPLETE : WAIT_DONE;
        err_d = abort ? gnt : '0;
        done_d = !abort && !m_busy ? gnt : '0;
      end
      COMPLETE: begin
        state_d = IDLE;
        gnt_d = '0;
        rr_ptr_d = idx == IW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      idx <= '0;
      gnt <= '0;
      done <= '0;
      err <= '0;
      m_start <= 1'b0;
      m_header <= '0;
      m_data <= '0;
    end else begin
      state <= state_d;
      rr_ptr <= rr_ptr_d;
      idx <= idx_d;
      gnt <= gnt_d;
      done <= done_d;
      err <= err_d;
      m_start <= m_start_d;
      m_header <= hdr_d;
      m_data <= dat_d;
    end
endmodule

// File: tb/tb_fcp6_txn_arbiter.sv
// tb_fcp6_txn_arbiter: directed bench for fcp6_txn_arbiter with a small FCP6 master model.
module tb_fcp6_txn_arbiter;
`ifdef FCP6_ARB_WDOG_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0;
  logic [31:0] req_header = '0, req_data = '0;
  logic [3:0] gnt, done, err;
  logic m_start, arb_busy, m_busy;
  logic [7:0] m_header, m_data;
  logic mbusy_model, dly, force_busy = 1'b0, hang = 1'b0;
  int len = 3, mcnt;
  int errors = 0, checks = 0;

  fcp6_txn_arbiter #(.NUM_REQ(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_header(req_header), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .m_start(m_start), .m_header(m_header),
    .m_data(m_data), .m_busy(m_busy), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;
  assign m_busy = mbusy_model | force_busy;

  // Master: busy rises two cycles after start is sampled and stays high len cycles.
  always @(posedge clk or posedge rst)
    if (rst) begin
      dly <= 1'b0;
      mbusy_model <= 1'b0;
      mcnt <= 0;
    end else begin
      dly <= m_start & ~hang;
      if (dly) begin
        mbusy_model <= 1'b1;
        mcnt <= len - 1;
      end else if (mbusy_model) begin
        if (mcnt == 0) mbusy_model <= 1'b0;
        else mcnt <= mcnt - 1;
      end
    end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    force_busy = 1'b0;
    hang = 1'b0;
    len = 3;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({gnt, done, err, m_start, m_header, m_data, arb_busy} !== '0)
      begin errors++; $display("FAIL reset_outputs gnt=%b done=%b err=%b start=%b hdr=%h dat=%h busy=%b exp all 0", gnt, done, err, m_start, m_header, m_data, arb_busy); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [3:0] exp_done;
    do_reset;
    req = 4'b0001;
    req_header[7:0] = 8'hA5;
    req_data[7:0] = 8'h3C;
    @(negedge clk);
    checks++;
    if ({gnt, m_start, m_header, m_data, arb_busy} !== {4'b0001, 1'b1, 8'hA5, 8'h3C, 1'b1})
      begin errors++; $display("FAIL single_launch gnt=%b start=%b hdr=%h dat=%h exp 0001 1 a5 3c", gnt, m_start, m_header, m_data); end
    req = '0;
    req_header[7:0] = 8'hFF;
    req_data[7:0] = 8'h00;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      exp_done = k == 7 ? 4'b0001 : 4'b0000;
      checks++;
      if (done !== exp_done || m_start !== 1'b0 || err !== 4'b0)
        begin errors++; $display("FAIL single_cycle%0d done=%b start=%b err=%b exp done=%b start=0 err=0", k, done, m_start, err, exp_done); end
      if (k == 4) begin
        checks++;
        if ({gnt, m_header, m_data} !== {4'b0001, 8'hA5, 8'h3C})
          begin errors++; $display("FAIL single_hold gnt=%b hdr=%h dat=%h exp 0001 a5 3c", gnt, m_header, m_data); end
      end
    end
    @(negedge clk);
    checks++;
    if ({done, gnt, arb_busy, m_header, m_data} !== {4'b0, 4'b0, 1'b0, 8'hA5, 8'h3C})
      begin errors++; $display("FAIL single_after done=%b gnt=%b busy=%b hdr=%h dat=%h exp 0 0 0 a5 3c", done, gnt, arb_busy, m_header, m_data); end
  endtask

  task automatic test_round_robin;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    int n = 0, last_done = -1, onehot_bad = 0, double_done = 0;
    logic [3:0] prev_done = '0;
    do_reset;
    req_header = 32'h44332211;
    req = 4'hF;
    for (int cyc = 0; cyc < 300 && n < 5; cyc++) begin
      @(negedge clk);
      if (gnt != 0 && !$onehot(gnt)) onehot_bad++;
      if (done != 0 && prev_done != 0) double_done++;
      prev_done = done;
      if (done != 0) last_done = cyc;
      if (m_start) begin
        checks++;
        if (gnt !== (4'b0001 << exp_seq[n]) || m_header !== 8'(8'h11 * (exp_seq[n] + 1)))
          begin errors++; $display("FAIL rr_grant%0d gnt=%b hdr=%h exp client %0d", n, gnt, m_header, exp_seq[n]); end
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done != 2)
            begin errors++; $display("FAIL back_to_back gap=%0d exp 2", cyc - last_done); end
        end
        n++;
      end
    end
    req = '0;
    checks++;
    if (n != 5) begin errors++; $display("FAIL rr_count grants=%0d exp 5", n); end
    checks++;
    if (onehot_bad != 0) begin errors++; $display("FAIL rr_onehot bad_cycles=%0d exp 0", onehot_bad); end
    checks++;
    if (double_done != 0) begin errors++; $display("FAIL rr_done_pulse long_pulses=%0d exp 0", double_done); end
  endtask

  task automatic test_busy_hold;
    int bad = 0, served0 = 0, done1 = 0;
    do_reset;
    req_header = 32'h00005A00;
    force_busy = 1'b1;
    req = 4'b0001;
    repeat (3) @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);
    req = 4'b0010;
    repeat (6) begin
      @(negedge clk);
      if (gnt !== 4'b0 || m_start !== 1'b0 || arb_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL busy_blocks bad_cycles=%0d exp 0", bad); end
    force_busy = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt, m_start, m_header} !== {4'b0010, 1'b1, 8'h5A})
      begin errors++; $display("FAIL busy_release gnt=%b start=%b hdr=%h exp 0010 1 5a", gnt, m_start, m_header); end
    req = '0;
    repeat (20) begin
      @(negedge clk);
      if (m_start && gnt === 4'b0001) served0++;
      if (done === 4'b0010) done1++;
    end
    checks++;
    if (served0 != 0 || done1 != 1)
      begin errors++; $display("FAIL dropped_req served0=%0d done1=%0d exp 0 1", served0, done1); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    req = 4'b0010;
    for (int i = 0; i < 30 && done == 4'b0; i++) begin
      @(negedge clk);
      if (m_start) req = '0;
    end
    len = 10;
    req = 4'b0100;
    for (int i = 0; i < 10 && !m_start; i++) @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);
    checks++;
    if ({gnt, arb_busy, m_busy} !== {4'b0100, 1'b1, 1'b1})
      begin errors++; $display("FAIL mid_pre gnt=%b busy=%b m_busy=%b exp 0100 1 1", gnt, arb_busy, m_busy); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, done, err, m_start, m_header, m_data, arb_busy} !== '0)
      begin errors++; $display("FAIL mid_reset gnt=%b done=%b err=%b start=%b hdr=%h dat=%h busy=%b exp all 0", gnt, done, err, m_start, m_header, m_data, arb_busy); end
    req = 4'b1010;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt, m_start, done, err} !== {4'b0010, 1'b1, 4'b0, 4'b0})
      begin errors++; $display("FAIL mid_regrant gnt=%b start=%b done=%b err=%b exp 0010 1 0 0", gnt, m_start, done, err); end
    req = '0;
  endtask

  task automatic test_watchdog;
    logic [3:0] exp_err;
    do_reset;
    hang = 1'b1;
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if ({gnt, m_start} !== {4'b0100, 1'b1})
      begin errors++; $display("FAIL wdog_launch gnt=%b start=%b exp 0100 1", gnt, m_start); end
    req = '0;
`ifdef FCP6_ARB_WDOG_EN
    for (int k = 2; k <= 18; k++) begin
      @(negedge clk);
      exp_err = k == 18 ? 4'b0100 : 4'b0000;
      checks++;
      if (err !== exp_err || done !== 4'b0)
        begin errors++; $display("FAIL wdog_cycle%0d err=%b done=%b exp err=%b done=0", k, err, done, exp_err); end
    end
    hang = 1'b0;
    req = 4'b1111;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, m_start} !== {4'b1000, 1'b1})
      begin errors++; $display("FAIL wdog_next gnt=%b start=%b exp 1000 1", gnt, m_start); end
`else
    exp_err = 4'b0;
    repeat (40) @(negedge clk);
    checks++;
    if ({err, done, gnt, arb_busy} !== {exp_err, 4'b0, 4'b0100, 1'b1})
      begin errors++; $display("FAIL no_wdog_wait err=%b done=%b gnt=%b busy=%b exp 0 0 0100 1", err, done, gnt, arb_busy); end
`endif
    req = '0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_busy_hold;
    test_reset_mid;
    test_watchdog;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim_time=%0t exp finish earlier", $time);
    $fatal(1);
  end
endmodule
